// File: rtl/data_sram_responder.sv
// Data-side SRAM-like slave: word memory plus an in-order response queue.
// Every accepted request answers with one data_ok pulse a fixed LATENCY after acceptance.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  input  logic        accept_block,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [2:0]       OUT_MAX  = 3'(OUTSTANDING);
  localparam logic [3:0]       LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  widx;
  logic [31:0]            rd_word;

  logic [OUTSTANDING-1:0] vld_q, vld_d;
  logic [3:0]             cnt_q [OUTSTANDING];
  logic [3:0]             cnt_d [OUTSTANDING];
  logic                   wr_q  [OUTSTANDING];
  logic [31:0]            data_q [OUTSTANDING];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [2:0]             count_q, count_d;

  logic accept;
  logic pop;
  logic unused_bits;

  // Size is informational; address bits outside the word index alias away.
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  assign widx    = data_sram_addr[ADDR_WIDTH+1:2];
  assign rd_word = mem_q[widx];

  // No look-ahead at a same-cycle pop: a full queue refuses even while draining.
  assign data_sram_addr_ok = !reset && !accept_block && (count_q < OUT_MAX);
  assign accept            = data_sram_req && data_sram_addr_ok;

  assign pop               = vld_q[head_q] && (cnt_q[head_q] == 4'd0);
  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = (pop && !wr_q[head_q]) ? data_q[head_q] : 32'h0;

  always_comb begin
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < OUTSTANDING; i++) begin
      cnt_d[i] = (vld_q[i] && cnt_q[i] != 4'd0) ? cnt_q[i] - 4'd1 : cnt_q[i];
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end
    // Tail never equals head here unless the queue is empty, so no clash with the pop.
    if (accept) begin
      vld_d[tail_q] = 1'b1;
      cnt_d[tail_q] = LAT_LOAD;
      tail_d        = ptr_inc(tail_q);
    end
    count_d = count_q + {2'b00, accept} - {2'b00, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) cnt_q[i] <= 4'd0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < OUTSTANDING; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Entry payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q[tail_q]   <= data_sram_wr;
      data_q[tail_q] <= data_sram_wr ? 32'h0 : rd_word;
    end
  end

  // Memory survives reset; only lanes with a strobe set are updated.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem_q[widx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized scoreboard bench for data_sram_responder with a transaction-level memory model.
module tb_data_sram_responder;
  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int OUTS  = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        accept_block;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdl_mem [DEPTH];
  int unsigned ecnt = 0;
  int          checks = 0;
  int          failures = 0;

  data_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .OUTSTANDING(OUTS)) dut (
    .clk(clk), .reset(reset),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .accept_block(accept_block),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // One bus cycle: drive at negedge, check addr_ok, and on acceptance update the model.
  task automatic drive(input logic req, input logic wr, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input logic blk,
                       output logic acc);
    logic        exp_ok;
    int unsigned idx;
    exp_t        e;
    @(negedge clk);
    data_sram_req   = req;
    data_sram_wr    = wr;
    data_sram_addr  = addr;
    data_sram_wstrb = strb;
    data_sram_wdata = wd;
    data_sram_size  = 2'($urandom_range(0, 2));
    accept_block    = blk;
    #1;
    exp_ok = !reset && !blk && (sb.size() < OUTS);
    chk("addr_ok", {31'b0, data_sram_addr_ok}, {31'b0, exp_ok});
    acc = req && exp_ok;
    if (acc) begin
      idx    = (addr >> 2) % DEPTH;
      e.due  = ecnt + LAT;
      e.data = wr ? 32'h0 : mdl_mem[idx];
      sb.push_back(e);
      if (wr) for (int i = 0; i < 4; i++) if (strb[i]) mdl_mem[idx][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd);
    logic acc = 1'b0;
    int   tries = 0;
    while (!acc && tries < 20) begin
      drive(1'b1, wr, addr, strb, wd, 1'b0, acc);
      tries++;
    end
    chk("xfer accepted", {31'b0, acc}, 32'h1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, acc);
  endtask

  // Monitor: every data_ok must match the oldest expected response, in its exact cycle.
  always @(negedge clk) begin
    #2;
    if (data_sram_data_ok) begin
      if (sb.size() == 0) begin
        chk("spurious data_ok", {31'b0, data_sram_data_ok}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("data_ok cycle", ecnt, mon_e.due);
        chk("rdata", data_sram_rdata, mon_e.data);
      end
    end else begin
      chk("rdata idle", data_sram_rdata, 32'h0);
      if (sb.size() > 0 && sb[0].due <= ecnt) begin
        mon_e = sb.pop_front();
        chk("missing data_ok", {31'b0, data_sram_data_ok}, 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   n;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    reset = 1'b1;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_addr = '0; data_sram_wstrb = '0; data_sram_wdata = '0; accept_block = 1'b0;
    @(negedge clk); #1;
    chk("reset addr_ok", {31'b0, data_sram_addr_ok}, 32'h0);
    chk("reset data_ok", {31'b0, data_sram_data_ok}, 32'h0);
    chk("reset rdata", data_sram_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Preload the words the random phase uses.
    for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), 4'hF, $urandom);

    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    xfer(1'b1, 32'h11, 4'b0010, 32'h0000AA00);
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    xfer(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    idle(4);

    // Request held high: acceptance throttled by the queue bound.
    n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      drive(1'b1, 1'b0, 32'((n + 2) * 4), 4'h0, 32'h0, 1'b0, acc);
      if (acc) n++;
    end
    chk("held reads accepted", n, 32'd6);
    idle(4);

    xfer(1'b1, 32'h0, 4'hF, 32'h12345678);
    xfer(1'b0, 32'h0, 4'h0, 32'h0);
    xfer(1'b0, 32'h1000, 4'h0, 32'h0);
    idle(4);

    // Reset while two reads are pending: their responses must vanish.
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    xfer(1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    data_sram_req = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    chk("mid reset addr_ok", {31'b0, data_sram_addr_ok}, 32'h0);
    chk("mid reset data_ok", {31'b0, data_sram_data_ok}, 32'h0);
    reset = 1'b0;
    xfer(1'b0, 32'h10, 4'h0, 32'h0);
    xfer(1'b0, 32'h0, 4'h0, 32'h0);
    idle(4);

    // Throttle with an entry in flight.
    xfer(1'b0, 32'h8, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 32'hC, 4'h0, 32'h0, 1'b1, acc);
    drive(1'b1, 1'b0, 32'hC, 4'h0, 32'h0, 1'b1, acc);
    drive(1'b1, 1'b0, 32'hC, 4'h0, 32'h0, 1'b0, acc);
    chk("release accepts", {31'b0, acc}, 32'h1);
    idle(4);

    for (int c = 0; c < 300; c++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      drive(($urandom % 4) != 0, $urandom % 2 == 0, a, 4'($urandom), $urandom,
            ($urandom % 8) == 0, acc);
    end

    idle(LAT + 4);
    chk("drain", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
